// File: rtl/div_result_pkg.sv
// Shared constants and types for the divider result collector: IEEE single-precision
// widths, exception flag bit positions and the buffered entry layout.
package div_result_pkg;

   localparam int F32_EXP_WIDTH = 8;
   localparam int F32_SIG_WIDTH = 24;
   localparam int F32_IEEE_W    = F32_EXP_WIDTH + F32_SIG_WIDTH;
   localparam int F32_REC_W     = F32_EXP_WIDTH + F32_SIG_WIDTH + 1;

   localparam int FLAG_W         = 5;
   localparam int FLAG_INVALID   = 4;
   localparam int FLAG_INFINITE  = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   typedef logic [FLAG_W-1:0] div_flags_t;

   typedef struct packed {
      logic [F32_IEEE_W-1:0] data;
      div_flags_t            flags;
   } div_entry_t;

   // Width of one buffered entry: IEEE word followed by the five flags.
   function automatic int entry_width(input int exp_w, input int sig_w);
      return exp_w + sig_w + FLAG_W;
   endfunction

endpackage

// File: rtl/div_res_fifo.sv
// Synchronous FIFO with asynchronous active-high reset. The caller never pushes when
// full without a same-cycle pop and never pops when empty.
module div_res_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;

   // Storage, wrapping pointers and occupancy; entries clear on reset so an empty head reads zero
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_i) begin
            mem_r[wr_ptr_r] <= data_i;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_i) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_i, pop_i})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign data_o  = mem_r[rd_ptr_r];
   assign empty_o = (count_r == '0);
   assign full_o  = (count_r == DEPTH_C);

endmodule

// File: rtl/recFNToFN.sv
// Recoded (HardFloat) to standard IEEE conversion; interface matches HardFloat recFNToFN.
// Recoded exponent = true exponent + 2^expWidth; top three bits 000 = zero, 11x = special.
module recFNToFN #(
   parameter int expWidth = 8,
   parameter int sigWidth = 24
) (
   input  logic [expWidth+sigWidth:0]   in,
   output logic [expWidth+sigWidth-1:0] out
);

   localparam int FW = sigWidth - 1;
   localparam logic [expWidth:0] MIN_NORM_EXP = (expWidth+1)'((1 << (expWidth - 1)) + 2);
   localparam logic [expWidth:0] NORM_ADJ     = (expWidth+1)'((1 << (expWidth - 1)) + 1);

   logic                sign_s;
   logic [expWidth:0]   rexp_s;
   logic [FW-1:0]       fract_s;
   logic                is_zero_s;
   logic                is_special_s;
   logic                is_nan_s;
   logic                is_subnormal_s;
   logic [expWidth:0]   denorm_dist_s;
   logic [FW-1:0]       denorm_fract_s;
   logic [expWidth-1:0] norm_exp_s;
   logic [expWidth-1:0] out_exp_s;
   logic [FW-1:0]       out_fract_s;

   assign sign_s         = in[expWidth+sigWidth];
   assign rexp_s         = in[expWidth+sigWidth-1 -: expWidth+1];
   assign fract_s        = in[FW-1:0];
   assign is_zero_s      = (rexp_s[expWidth -: 3] == 3'b000);
   assign is_special_s   = (rexp_s[expWidth -: 2] == 2'b11);
   assign is_nan_s       = is_special_s && rexp_s[expWidth-2];
   assign is_subnormal_s = (rexp_s < MIN_NORM_EXP);
   // Subnormals re-insert the hidden one and shift it down into the fraction field.
   assign denorm_dist_s  = MIN_NORM_EXP - rexp_s;
   assign denorm_fract_s = FW'({!is_zero_s, fract_s} >> denorm_dist_s);
   assign norm_exp_s     = expWidth'(rexp_s - NORM_ADJ);

   // Field selection per number class
   always_comb begin
      out_exp_s   = norm_exp_s;
      out_fract_s = fract_s;
      if (is_subnormal_s) begin
         out_exp_s   = '0;
         out_fract_s = denorm_fract_s;
      end else if (is_special_s) begin
         out_exp_s   = '1;
         out_fract_s = is_nan_s ? fract_s : '0;
      end else begin
         out_exp_s   = norm_exp_s;
         out_fract_s = fract_s;
      end
   end

   assign out = {sign_s, out_exp_s, out_fract_s};

endmodule

// File: rtl/div_result_collector.sv
// Collects divider results (which cannot be stalled) into a small buffer, converts them
// to IEEE format, and meters issue with a credit counter so the buffer never overruns.
module div_result_collector
   import div_result_pkg::*;
#(
   parameter int EXP_WIDTH = 8,
   parameter int SIG_WIDTH = 24,
   parameter int DEPTH     = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           issue_fire_i,
   output logic                           issue_ok_o,
   input  logic                           div_out_valid_i,
   input  logic [EXP_WIDTH+SIG_WIDTH:0]   div_out_i,
   input  logic [4:0]                     div_flags_i,
   output logic                           res_valid_o,
   input  logic                           res_ready_i,
   output logic [EXP_WIDTH+SIG_WIDTH-1:0] res_data_o,
   output logic [4:0]                     res_flags_o,
   output logic [4:0]                     sticky_flags_o,
   input  logic                           clear_flags_i,
   output logic                           overflow_o
);

   localparam int DATA_W  = EXP_WIDTH + SIG_WIDTH;
   localparam int ENTRY_W = entry_width(EXP_WIDTH, SIG_WIDTH);
   localparam int CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [DATA_W-1:0]  ieee_s;
   logic [ENTRY_W-1:0] head_s;
   logic               empty_s;
   logic               full_s;
   logic               pop_s;
   logic               capture_s;
   logic               drop_s;
   logic               over_issue_s;
   logic [CW-1:0]      cnt_r;
   logic [CW-1:0]      cnt_nxt_s;
   logic [FLAG_W-1:0]  sticky_r;
   logic [FLAG_W-1:0]  sticky_nxt_s;
   logic               overflow_r;

   recFNToFN #(
      .expWidth (EXP_WIDTH),
      .sigWidth (SIG_WIDTH)
   ) u_rec_to_ieee (
      .in  (div_out_i),
      .out (ieee_s)
   );

   div_res_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (capture_s),
      .pop_i   (pop_s),
      .data_i  ({ieee_s, div_flags_i}),
      .data_o  (head_s),
      .empty_o (empty_s),
      .full_o  (full_s)
   );

   // A full buffer still accepts a result when the head leaves in the same cycle.
   assign pop_s     = !empty_s && res_ready_i;
   assign capture_s = div_out_valid_i && (!full_s || pop_s);
   assign drop_s    = div_out_valid_i && full_s && !pop_s;

   // Credit counter next state and over-issue detection
   always_comb begin
      cnt_nxt_s    = cnt_r;
      over_issue_s = 1'b0;
      case ({issue_fire_i, pop_s})
         2'b10: begin
            if (cnt_r == DEPTH_C) begin
               over_issue_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CW'(1);
            end
         end
         2'b01: begin
            if (cnt_r != '0) begin
               cnt_nxt_s = cnt_r - CW'(1);
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         default: cnt_nxt_s = cnt_r;
      endcase
   end

   // Sticky flags: a clear discards history but keeps flags captured in the same cycle
   always_comb begin
      sticky_nxt_s = (clear_flags_i ? '0 : sticky_r) | (capture_s ? div_flags_i : '0);
   end

   // Credit, sticky-flag and protocol-error registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_r      <= '0;
         sticky_r   <= '0;
         overflow_r <= 1'b0;
      end else begin
         cnt_r      <= cnt_nxt_s;
         sticky_r   <= sticky_nxt_s;
         overflow_r <= overflow_r | over_issue_s | drop_s;
      end
   end

   assign issue_ok_o     = (cnt_r < DEPTH_C);
   assign res_valid_o    = !empty_s;
   assign res_data_o     = head_s[ENTRY_W-1 -: DATA_W];
   assign res_flags_o    = head_s[FLAG_W-1:0];
   assign sticky_flags_o = sticky_r;
   assign overflow_o     = overflow_r;

endmodule

// File: tb/tb_div_result_collector.sv
// Randomized and directed bench for div_result_collector with a queue-based reference
// model and a negedge monitor comparing every DUT output against it.
module tb_div_result_collector;
   import div_result_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        issue_fire_i;
   logic        issue_ok_o;
   logic        div_out_valid_i;
   logic [32:0] div_out_i;
   logic [4:0]  div_flags_i;
   logic        res_valid_o;
   logic        res_ready_i;
   logic [31:0] res_data_o;
   logic [4:0]  res_flags_o;
   logic [4:0]  sticky_flags_o;
   logic        clear_flags_i;
   logic        overflow_o;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] cur_ieee;
   int          inflight;

   // reference model state
   div_entry_t  m_q[$];
   int          m_credits = 0;
   logic [4:0]  m_sticky = 5'd0;
   logic        m_ovf = 1'b0;

   div_result_collector #(.EXP_WIDTH(8), .SIG_WIDTH(24), .DEPTH(DEPTH)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .issue_fire_i   (issue_fire_i),
      .issue_ok_o     (issue_ok_o),
      .div_out_valid_i(div_out_valid_i),
      .div_out_i      (div_out_i),
      .div_flags_i    (div_flags_i),
      .res_valid_o    (res_valid_o),
      .res_ready_i    (res_ready_i),
      .res_data_o     (res_data_o),
      .res_flags_o    (res_flags_o),
      .sticky_flags_o (sticky_flags_o),
      .clear_flags_i  (clear_flags_i),
      .overflow_o     (overflow_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // IEEE single to HardFloat recoded form, from the value's meaning:
   // recoded exponent = unbiased exponent + 256; zero 000..., inf 110..., NaN 111...
   function automatic logic [32:0] rec_of(input logic [31:0] f);
      int          e;
      int          p;
      logic [22:0] m;
      logic [8:0]  rx;
      logic [22:0] rf;
      m = f[22:0];
      e = int'(f[30:23]);
      if (e == 0 && m == 23'd0) begin
         rx = 9'd0;
         rf = 23'd0;
      end else if (e == 255) begin
         rx = (m != 23'd0) ? 9'h1c0 : 9'h180;
         rf = m;
      end else if (e == 0) begin
         p = 22;
         while (!m[p]) p--;
         rx = 9'(p - 149 + 256);
         rf = m << (23 - p);
      end else begin
         rx = 9'((e - 127) + 256);
         rf = m;
      end
      return {f[31], rx, rf};
   endfunction

   function automatic logic [31:0] rand_f32();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 7))
         0: v[30:23] = 8'd0;
         1: v[30:0]  = 31'd0;
         2: begin v[30:23] = 8'hff; v[22:0] = 23'd0; end
         3: v[30:23] = 8'hff;
         default: ;
      endcase
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
      issue_fire_i    = 1'b0;
      div_out_valid_i = 1'b0;
      clear_flags_i   = 1'b0;
   endtask

   task automatic put_result(input logic [31:0] f, input logic [4:0] fl);
      div_out_valid_i = 1'b1;
      div_out_i       = rec_of(f);
      div_flags_i     = fl;
      cur_ieee        = f;
   endtask

   task automatic issue_n(input int n);
      for (int i = 0; i < n; i++) begin
         issue_fire_i = 1'b1;
         cyc();
      end
   endtask

   // Reference model + monitor: compare what the DUT shows, then advance on the inputs
   // that the coming rising edge will see.
   initial begin
      logic       pop;
      logic       cap;
      div_entry_t ent;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            m_q.delete();
            m_credits = 0;
            m_sticky  = 5'd0;
            m_ovf     = 1'b0;
            chk("rst_data", res_data_o, 32'd0);
            chk("rst_flags", res_flags_o, 5'd0);
         end
         chk("res_valid", res_valid_o, m_q.size() != 0);
         chk("issue_ok", issue_ok_o, m_credits < DEPTH);
         chk("sticky", sticky_flags_o, m_sticky);
         chk("overflow", overflow_o, m_ovf);
         if (m_q.size() != 0) begin
            chk("head_data", res_data_o, m_q[0].data);
            chk("head_flags", res_flags_o, m_q[0].flags);
         end
         if (!rst_i) begin
            pop = (m_q.size() != 0) && res_ready_i;
            cap = div_out_valid_i && ((m_q.size() < DEPTH) || pop);
            if (div_out_valid_i && !cap) m_ovf = 1'b1;
            if (issue_fire_i && !pop) begin
               if (m_credits == DEPTH) m_ovf = 1'b1;
               else m_credits++;
            end else if (pop && !issue_fire_i && m_credits > 0) begin
               m_credits--;
            end
            m_sticky = (clear_flags_i ? 5'd0 : m_sticky) | (cap ? div_flags_i : 5'd0);
            if (pop) void'(m_q.pop_front());
            if (cap) begin
               ent.data  = cur_ieee;
               ent.flags = div_flags_i;
               m_q.push_back(ent);
            end
         end
      end
   end

   initial begin
      logic do_issue;
      rst_i           = 1'b1;
      issue_fire_i    = 1'b0;
      div_out_valid_i = 1'b0;
      div_out_i       = 33'd0;
      div_flags_i     = 5'd0;
      res_ready_i     = 1'b0;
      clear_flags_i   = 1'b0;
      cur_ieee        = 32'd0;
      inflight        = 0;
      repeat (3) cyc();
      rst_i = 1'b0;
      cyc();

      // 12/3 -> 4.0, visible the cycle after the divider pulse
      res_ready_i = 1'b1;
      issue_n(1);
      cyc();
      put_result(32'h40800000, 5'b00000);
      cyc();
      chk("div12_3_valid", res_valid_o, 1'b1);
      chk("div12_3_data", res_data_o, 32'h40800000);
      chk("div12_3_flags", res_flags_o, 5'b00000);
      cyc();

      // two inexact results held while downstream stalls, then popped in order
      res_ready_i = 1'b0;
      issue_n(2);
      put_result(32'hc0075075, 5'b00001);
      cyc();
      put_result(32'h3ddc897c, 5'b00001);
      cyc();
      repeat (3) begin
         chk("hold_data", res_data_o, 32'hc0075075);
         cyc();
      end
      chk("hold_sticky", sticky_flags_o, 5'b00001);
      res_ready_i = 1'b1;
      cyc();
      chk("second_data", res_data_o, 32'h3ddc897c);
      chk("second_flags", res_flags_o, 5'b00001);
      cyc();

      // clear coinciding with capture of 1.0/0.0 keeps only the new flags
      issue_n(1);
      put_result(32'h7f800000, 5'b01000);
      clear_flags_i = 1'b1;
      cyc();
      chk("clr_sticky", sticky_flags_o, 5'b01000);
      chk("clr_data", res_data_o, 32'h7f800000);
      cyc();

      // randomized legal traffic: results only for outstanding issues
      for (int c = 0; c < 500; c++) begin
         do_issue     = issue_ok_o && ($urandom_range(0, 2) == 0);
         issue_fire_i = do_issue;
         if (inflight > 0 && $urandom_range(0, 2) != 0) begin
            put_result(rand_f32(), 5'($urandom_range(0, 31)));
            inflight--;
         end
         if (do_issue) inflight++;
         res_ready_i   = ($urandom_range(0, 1) == 1);
         clear_flags_i = ($urandom_range(0, 15) == 0);
         cyc();
      end
      res_ready_i = 1'b1;
      for (int k = 0; k < 200 && (inflight > 0 || res_valid_o); k++) begin
         if (inflight > 0) begin
            put_result(rand_f32(), 5'($urandom_range(0, 31)));
            inflight--;
         end
         cyc();
      end
      chk("drain_done", res_valid_o, 1'b0);
      chk("drain_ok", issue_ok_o, 1'b1);

      // full buffer drops a forced result and flags a protocol error
      clear_flags_i = 1'b1;
      res_ready_i   = 1'b0;
      cyc();
      issue_n(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         put_result(32'h3f800000 + 32'(i), 5'b00010);
         cyc();
      end
      chk("full_no_ovf", overflow_o, 1'b0);
      put_result(32'h12345678, 5'b10000);
      cyc();
      chk("drop_ovf", overflow_o, 1'b1);
      chk("drop_sticky", sticky_flags_o, 5'b00010);
      chk("drop_head", res_data_o, 32'h3f800000);
      res_ready_i = 1'b1;
      cyc();
      cyc();
      res_ready_i = 1'b0;
      cyc();

      // reset with two entries buffered; a divider pulse during reset is ignored
      chk("pre_rst_valid", res_valid_o, 1'b1);
      rst_i = 1'b1;
      #1;
      chk("rst_valid", res_valid_o, 1'b0);
      chk("rst_issue_ok", issue_ok_o, 1'b1);
      chk("rst_sticky", sticky_flags_o, 5'd0);
      chk("rst_ovf", overflow_o, 1'b0);
      put_result(32'h40000000, 5'b00100);
      cyc();
      cyc();
      rst_i = 1'b0;
      cyc();
      chk("post_rst_valid", res_valid_o, 1'b0);

      // over-issue: DEPTH credits, then one more
      for (int i = 0; i < DEPTH + 1; i++) begin
         issue_fire_i = 1'b1;
         cyc();
         if (i == DEPTH - 1) begin
            chk("credits_exhausted", issue_ok_o, 1'b0);
            chk("credits_no_ovf", overflow_o, 1'b0);
         end
      end
      chk("over_issue_ovf", overflow_o, 1'b1);
      chk("over_issue_ok", issue_ok_o, 1'b0);
      cyc();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/div_result_collector.md
DIV_RESULT_COLLECTOR -- requirements
Module: div_result_collector

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent width of the IEEE format.
REQ-002 SHALL have parameter SIG_WIDTH, default 24, significand width including hidden bit.
REQ-003 SHALL have parameter DEPTH, default 4, result buffer entries (power of two, 2..16).
REQ-004 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port issue_fire_i  input  1  one operation accepted by the divider this cycle (inValid && inReady).
REQ-007 SHALL have port issue_ok_o  output  1  upstream may issue a new divide this cycle.
REQ-008 SHALL have port div_out_valid_i  input  1  divider result pulse (outValid); cannot be stalled.
REQ-009 SHALL have port div_out_i  input  EXP_WIDTH+SIG_WIDTH+1  recoded divider result.
REQ-010 SHALL have port div_flags_i  input  5  divider exceptionFlags {invalid, infinite, overflow, underflow, inexact}.
REQ-011 SHALL have port res_valid_o  output  1  buffer head holds a result.
REQ-012 SHALL have port res_ready_i  input  1  downstream accepts head this cycle.
REQ-013 SHALL have port res_data_o  output  EXP_WIDTH+SIG_WIDTH  head result in standard IEEE format.
REQ-014 SHALL have port res_flags_o  output  5  exception flags of head result.
REQ-015 SHALL have port sticky_flags_o  output  5  OR of flags of all captured results since last clear.
REQ-016 SHALL have port clear_flags_i  input  1  clears sticky_flags_o.
REQ-017 SHALL have port overflow_o  output  1  sticky protocol error (dropped result or over-issue).

Function
REQ-018 SHALL convert div_out_i to IEEE format combinationally before capture; buffer stores IEEE data plus 5 flags per entry.
REQ-019 SHALL capture on the rising edge where div_out_valid_i=1 and buffer not full; res_valid_o rises the following cycle (latency 1).
REQ-020 SHALL pop the head on a rising edge where res_valid_o && res_ready_i; res_data_o/res_flags_o SHALL hold stable while res_valid_o && !res_ready_i.
REQ-021 SHALL deliver results in capture order; pointers wrap modulo DEPTH.
REQ-022 SHALL, on simultaneous capture and pop when full, perform both (occupancy unchanged); when empty, pop is impossible and capture proceeds.
REQ-023 SHALL keep credit counter cnt (0..DEPTH) = issued-but-not-popped: +1 on issue_fire_i, -1 on pop, unchanged when both.
REQ-024 SHALL drive issue_ok_o = (cnt < DEPTH) combinationally from registered cnt.
REQ-025 SHALL, on issue_fire_i with cnt==DEPTH and no pop, hold cnt at DEPTH and set overflow_o.
REQ-026 SHALL, on div_out_valid_i with buffer full and no same-cycle pop, drop the result, leave buffer unchanged, set overflow_o.
REQ-027 SHALL update sticky_flags_o <= (clear_flags_i ? 0 : sticky_flags_o) | captured flags; simultaneous clear and capture yields the new flags only.
REQ-028 SHALL NOT include flags of a dropped result in sticky_flags_o.
REQ-029 SHALL clear overflow_o only by reset.

Reset
REQ-030 SHALL, while rst_i=1, asynchronously force res_valid_o=0, issue_ok_o=1, cnt=0, pointers=0, sticky_flags_o=0, overflow_o=0; res_data_o/res_flags_o=0.
REQ-031 SHALL discard buffered and in-flight credit state on reset mid-operation; a divider pulse during reset SHALL be ignored.

Structure
REQ-032 SHALL place format width constants, flag bit indices (FLAG_INVALID=4..FLAG_INEXACT=0) and the entry struct in package div_result_pkg.
REQ-033 SHALL instantiate HardFloat recFNToFN for conversion and one sub-module div_res_fifo (synchronous FIFO, async active-high reset).

Verification
REQ-034 SHALL cover 12/3 through divSqrtRecFN_small, RNE -> res_data_o=0x40800000, res_flags_o=5'b00000, one cycle after outValid.
REQ-035 SHALL cover -37/17.5 then -1414/-13131 with res_ready_i=0 -> both held, popped in order 0xc0075075 then 0x3ddc897c, each flags 5'b00001, sticky_flags_o=5'b00001.
REQ-036 SHALL cover DEPTH+1 issue_fire_i pulses with no pops -> issue_ok_o=0 after 4th, overflow_o=1 after 5th, cnt=4.
REQ-037 SHALL cover forced div_out_valid_i while full -> result dropped, occupancy 4, overflow_o=1, sticky unchanged.
REQ-038 SHALL cover clear_flags_i same cycle as capture of 1.0/0.0 -> sticky_flags_o=5'b01000, res_data_o=0x7f800000.
REQ-039 SHALL cover rst_i asserted with 2 entries buffered -> res_valid_o=0 immediately, issue_ok_o=1, sticky and overflow zero.
